// File: rtl/vmem_pkg.sv
// Shared definitions for the video-memory write-port controller.
//   ADDR_W/DATA_W : default write address / pixel widths (8192 x RGB555)
//   ROW_W/COL_W   : address split, address = {row, col}
//   state_t       : controller states
//   BLACK         : colour used by the post-reset clear
//   pix_addr      : builds a memory address from row/column
package vmem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 15;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [14:0] BLACK = 15'h0;

    function automatic logic [ROW_W+COL_W-1:0] pix_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/vmem_wr_ctrl_if.sv
// Bundle of all handshake and memory-port signals of vmem_wr_ctrl.
//   req0/addr0/data0/ack0 : requester 0 (CPU store path)
//   req1/addr1/data1/ack1 : requester 1 (game/sprite logic)
//   clr_start/clr_color   : clear command and fill colour; clr_busy status
//   mem_waddr/wdata/web   : registered write port towards the vmem
// master = requesters + memory side, slave = the controller.
interface vmem_wr_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 15
);
    import vmem_pkg::*;

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_web;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, clr_start, clr_color,
        input  ack0, ack1, clr_busy, mem_waddr, mem_wdata, mem_web
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, clr_start, clr_color,
        output ack0, ack1, clr_busy, mem_waddr, mem_wdata, mem_web
    );

endinterface

// File: rtl/vmem_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   elig         : per-requester eligibility
//   last_gnt     : requester granted on the last tie-relevant grant (0/1)
//   gnt          : one-hot grant
//   last_gnt_nxt : value for the caller's last_gnt register
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       last_gnt_nxt
);
    import vmem_pkg::*;

    always_comb begin
        gnt          = '0;
        last_gnt_nxt = last_gnt;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // tie: the requester that did not win last time goes first
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
        if (gnt[0]) begin
            last_gnt_nxt = 1'b0;
        end else if (gnt[1]) begin
            last_gnt_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/vmem_wr_ctrl.sv
// Owner of the single vmem write port. Arbitrates two single-word
// requesters round-robin and runs a full-memory clear sequencer
// (after reset when RESET_CLEAR=1, and on clr_start).
//   clkb  : clock, also the vmem write-port clock
//   rst_n : synchronous active-low reset
//   bus   : requester handshakes, clear command/status, memory write port
// All outputs are registered; at most one write per cycle.
module vmem_wr_ctrl #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 15,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic           clkb,
    input  logic           rst_n,
    vmem_wr_ctrl_if.slave  bus
);
    import vmem_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              last_gnt_q, last_gnt_d;
    logic              mem_web_q, mem_web_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              clr_busy_q, clr_busy_d;

    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              arb_last_nxt;

    // A requester still holding req during its ack cycle is not eligible,
    // otherwise the same word would be written twice.
    assign elig = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

    rr_arb2 u_arb (
        .elig         (elig),
        .last_gnt     (last_gnt_q),
        .gnt          (gnt),
        .last_gnt_nxt (arb_last_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        last_gnt_d  = last_gnt_q;
        mem_web_d   = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    mem_web_d   = 1'b1;
                    mem_waddr_d = bus.addr0;
                    mem_wdata_d = bus.data0;
                    ack0_d      = 1'b1;
                end else if (gnt[1]) begin
                    mem_web_d   = 1'b1;
                    mem_waddr_d = bus.addr1;
                    mem_wdata_d = bus.data1;
                    ack1_d      = 1'b1;
                end
                last_gnt_d = arb_last_nxt;
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mem_web_d   = 1'b1;
                mem_waddr_d = cnt_q;
                mem_wdata_d = color_q;
                cnt_d       = cnt_q + ADDR_W'(1);
                // terminal-count compare: the counter never re-issues address 0
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Busy covers the cycle in which the final clear write is on the port.
        clr_busy_d = (state_q == CLEAR) || (state_d == CLEAR);
    end

    always_ff @(posedge clkb) begin
        if (!rst_n) begin
            state_q     <= RESET_CLEAR ? CLEAR : IDLE;
            cnt_q       <= '0;
            color_q     <= DATA_W'(BLACK);
            last_gnt_q  <= 1'b1;
            mem_web_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            clr_busy_q  <= RESET_CLEAR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            last_gnt_q  <= last_gnt_d;
            mem_web_q   <= mem_web_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            clr_busy_q  <= clr_busy_d;
        end
    end

    assign bus.mem_web   = mem_web_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_vmem_wr_ctrl.sv
// Self-checking bench for vmem_wr_ctrl (RESET_CLEAR=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vmem_wr_ctrl;
    import vmem_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 15;
    localparam int DEPTH = 1 << AW;

    logic clkb  = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    vmem_wr_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vmem_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_CLEAR(1'b1)) dut (
        .clkb  (clkb),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clkb = ~clkb;

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
        bus.clr_start = 1'b0; bus.clr_color = '0;
    endtask

    // Walks one full clear and records the first step that deviates from
    // "write address i with the fill colour, no acks, busy high".
    task automatic collect_clear(input logic [DW-1:0] color, input int restart_at,
                                 input logic [DW-1:0] restart_color,
                                 output int bad_idx, output logic [AW-1:0] bad_addr,
                                 output logic [DW-1:0] bad_data, output logic [3:0] bad_flags);
        bad_idx = -1; bad_addr = '0; bad_data = '0; bad_flags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clkb);
            if (bad_idx < 0 && (bus.mem_web !== 1'b1 || bus.mem_waddr !== AW'(i) ||
                bus.mem_wdata !== color || bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 ||
                bus.clr_busy !== 1'b1)) begin
                bad_idx   = i;
                bad_addr  = bus.mem_waddr;
                bad_data  = bus.mem_wdata;
                bad_flags = {bus.mem_web, bus.ack0, bus.ack1, bus.clr_busy};
            end
            bus.clr_start = (i == restart_at);
            if (i == restart_at) bus.clr_color = restart_color;
        end
    endtask

    task automatic test_reset();
        int bad; logic [AW-1:0] ba; logic [DW-1:0] bd; logic [3:0] bf;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clkb);
        checks++;
        if ({bus.mem_web, bus.ack0, bus.ack1, bus.clr_busy} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags: web/ack0/ack1/busy=%b want 0001",
                     {bus.mem_web, bus.ack0, bus.ack1, bus.clr_busy});
        end
        checks++;
        if (bus.mem_waddr !== '0 || bus.mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_port: addr=%h data=%h want 0/0", bus.mem_waddr, bus.mem_wdata);
        end
        rst_n = 1'b1;
        collect_clear(DW'(BLACK), -1, '0, bad, ba, bd, bf);
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL reset_clear_seq: step %0d web/ack0/ack1/busy=%b addr=%0d data=%h, want 1001 addr=%0d data=0",
                     bad, bf, ba, bd, bad);
        end
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0 || bus.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_clear_end: web=%b busy=%b want 0/0", bus.mem_web, bus.clr_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2+AW+DW:0] got, exp;
        logic [AW-1:0] a0 = 13'h1234, a1 = 13'h0777;
        logic [DW-1:0] d0 = 15'h2AAA, d1 = 15'h5555;
        bus.req0 = 1'b1; bus.addr0 = a0; bus.data0 = d0;
        bus.req1 = 1'b1; bus.addr1 = a1; bus.data1 = d1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clkb);
            got = {bus.mem_web, bus.ack0, bus.ack1, bus.mem_waddr, bus.mem_wdata};
            exp = (k % 2 == 0) ? {1'b1, 1'b1, 1'b0, a0, d0} : {1'b1, 1'b0, 1'b1, a1, d1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rr_order[%0d]: {web,ack0,ack1,addr,data}=%h want %h", k, got, exp);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0) begin
            failures++;
            $display("FAIL rr_release: web=%b want 0", bus.mem_web);
        end
    endtask

    task automatic test_single();
        logic [2+AW+DW:0] got, exp;
        bus.req0 = 1'b1; bus.addr0 = 13'h0A5; bus.data0 = 15'h7C00;
        @(negedge clkb);
        got = {bus.mem_web, bus.ack0, bus.ack1, bus.mem_waddr, bus.mem_wdata};
        exp = {1'b1, 1'b1, 1'b0, 13'h0A5, 15'h7C00};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL single_write: {web,ack0,ack1,addr,data}=%h want %h", got, exp);
        end
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0 || bus.ack0 !== 1'b0) begin
            failures++;
            $display("FAIL single_no_double: web=%b ack0=%b want 0/0", bus.mem_web, bus.ack0);
        end
        bus.req0 = 1'b0;
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0 || bus.mem_waddr !== 13'h0A5 || bus.mem_wdata !== 15'h7C00) begin
            failures++;
            $display("FAIL single_hold: web=%b addr=%h data=%h want 0/0a5/7c00",
                     bus.mem_web, bus.mem_waddr, bus.mem_wdata);
        end
    endtask

    // Random requesters: each keeps one outstanding word until acked.
    // Every write must belong to exactly one outstanding word, and with
    // round-robin no word waits more than 3 cycles.
    task automatic test_random();
        logic          act [2];
        logic [AW-1:0] ta  [2];
        logic [DW-1:0] td  [2];
        int            age [2];
        logic [1:0]    ack;
        int            issued = 0, completed = 0;
        for (int x = 0; x < 2; x++) begin act[x] = 1'b0; age[x] = 0; ta[x] = '0; td[x] = '0; end
        for (int cyc = 0; cyc < 320; cyc++) begin
            @(negedge clkb);
            ack = {bus.ack1, bus.ack0};
            checks++;
            if (ack == 2'b11 || bus.mem_web !== (ack != 2'b00)) begin
                failures++;
                $display("FAIL rand_port: cyc %0d web=%b acks=%b want web==|acks, one ack", cyc, bus.mem_web, ack);
            end
            for (int x = 0; x < 2; x++) begin
                if (act[x]) age[x]++;
                if (ack[x]) begin
                    checks++;
                    if (!act[x] || bus.mem_waddr !== ta[x] || bus.mem_wdata !== td[x]) begin
                        failures++;
                        $display("FAIL rand_write%0d: cyc %0d active=%b addr=%h data=%h want %h/%h",
                                 x, cyc, act[x], bus.mem_waddr, bus.mem_wdata, ta[x], td[x]);
                    end
                    act[x] = 1'b0;
                    completed++;
                end else if (act[x] && age[x] > 3) begin
                    checks++; failures++;
                    $display("FAIL rand_timeout%0d: cyc %0d waited %0d cycles, want <=3", x, cyc, age[x]);
                    act[x] = 1'b0;
                end
                if (!act[x] && cyc < 300 && $urandom_range(0, 1) == 1) begin
                    act[x] = 1'b1; age[x] = 0;
                    ta[x] = AW'($urandom); td[x] = DW'($urandom);
                    issued++;
                end
            end
            bus.req0 = act[0]; bus.addr0 = ta[0]; bus.data0 = td[0];
            bus.req1 = act[1]; bus.addr1 = ta[1]; bus.data1 = td[1];
        end
        checks++;
        if (completed != issued) begin
            failures++;
            $display("FAIL rand_count: completed=%0d want %0d", completed, issued);
        end
        idle_inputs();
        @(negedge clkb);
    endtask

    task automatic test_cmd_clear();
        int bad; logic [AW-1:0] ba; logic [DW-1:0] bd; logic [3:0] bf;
        logic [3+AW+DW:0] got, exp;
        bus.req1 = 1'b1; bus.addr1 = 13'h1ABC; bus.data1 = 15'h3C3C;
        bus.clr_start = 1'b1; bus.clr_color = 15'h001F;
        @(negedge clkb);
        bus.clr_start = 1'b0; bus.clr_color = 15'h7FFF;
        got = {bus.mem_web, bus.ack0, bus.ack1, bus.clr_busy, bus.mem_waddr, bus.mem_wdata};
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 13'h1ABC, 15'h3C3C};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL clr_start_grant: {web,ack0,ack1,busy,addr,data}=%h want %h", got, exp);
        end
        collect_clear(15'h001F, 100, 15'h03E0, bad, ba, bd, bf);
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL cmd_clear_seq: step %0d web/ack0/ack1/busy=%b addr=%0d data=%h, want 1001 addr=%0d data=001f",
                     bad, bf, ba, bd, bad);
        end
        @(negedge clkb);
        got = {bus.mem_web, bus.ack0, bus.ack1, bus.clr_busy, bus.mem_waddr, bus.mem_wdata};
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 13'h1ABC, 15'h3C3C};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL clr_end_grant: {web,ack0,ack1,busy,addr,data}=%h want %h", got, exp);
        end
        bus.req1 = 1'b0;
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0 || bus.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle: web=%b busy=%b want 0/0", bus.mem_web, bus.clr_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad; logic [AW-1:0] ba; logic [DW-1:0] bd; logic [3:0] bf;
        logic found = 1'b0;
        bus.clr_start = 1'b1; bus.clr_color = 15'h1234;
        @(negedge clkb);
        bus.clr_start = 1'b0;
        for (int n = 0; n < 4200 && !found; n++) begin
            @(negedge clkb);
            if (bus.mem_web === 1'b1 && bus.mem_waddr === 13'd4000) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midclr_reach: address 4000 not seen within 4200 cycles, want seen");
        end
        rst_n = 1'b0;
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0) begin
            failures++;
            $display("FAIL midclr_abort: web=%b want 0", bus.mem_web);
        end
        rst_n = 1'b1;
        collect_clear(DW'(BLACK), -1, '0, bad, ba, bd, bf);
        checks++;
        if (bad !== -1) begin
            failures++;
            $display("FAIL midclr_restart: step %0d web/ack0/ack1/busy=%b addr=%0d data=%h, want 1001 addr=%0d data=0",
                     bad, bf, ba, bd, bad);
        end
        @(negedge clkb);
        checks++;
        if (bus.mem_web !== 1'b0 || bus.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL midclr_end: web=%b busy=%b want 0/0", bus.mem_web, bus.clr_busy);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_single();
        test_random();
        test_cmd_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vmem_wr_ctrl.md
Name: vmem_wr_ctrl

Overview:
- Owns the single write port of the 8192x15 video memory (clkb side); the display read port is unaffected.
- Shares the port between two single-word requesters (req0 = CPU store path, req1 = game/sprite logic) using round-robin arbitration.
- Contains a clear sequencer that fills every word with one colour, automatically after reset and on command.
- Issues one registered write per cycle at most; memory address format is {row[5:0], col[6:0]}.

Parameters:
- ADDR_W, 13, write address width; depth = 2**ADDR_W.
- DATA_W, 15, pixel width (RGB 5:5:5).
- RESET_CLEAR, 1, 1 = run a clear with colour 0 after reset; 0 = go straight to IDLE after reset.

Ports:
- clkb  in  1  single clock; also the vmem write-port clock.
- rst_n  in  1  synchronous reset, active-low.
- req0  in  1  requester 0 write request; hold high with addr0/data0 stable until ack0.
- addr0  in  ADDR_W  requester 0 address.
- data0  in  DATA_W  requester 0 data.
- ack0  out  1  one-cycle pulse; requester 0 write issued.
- req1, addr1, data1, ack1: same as requester 0, for requester 1.
- clr_start  in  1  one-cycle pulse; start a full-memory clear.
- clr_color  in  DATA_W  fill colour, sampled when clr_start is accepted.
- clr_busy  out  1  high while a clear is in progress.
- mem_waddr  out  ADDR_W  to vmem addrb.
- mem_wdata  out  DATA_W  to vmem datab.
- mem_web  out  1  to vmem web; one word is written per high cycle.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low at an edge):
  - mem_web=0, mem_waddr=0, mem_wdata=0, ack0=ack1=0.
  - Internal state: clear counter=0, last_gnt=1 (req0 wins the first tie).
  - If RESET_CLEAR=1: state=CLEAR, latched colour=0, clr_busy=1.
  - If RESET_CLEAR=0: state=IDLE, clr_busy=0.
- States: IDLE, CLEAR.
- IDLE, arbitration per cycle:
  - Eligible requester: reqX=1 and ackX=0 in the current cycle. This masking stops a requester that still holds req in its ack cycle from being written twice.
  - One eligible: that requester is granted.
  - Both eligible: the requester other than last_gnt is granted, then last_gnt is updated.
- Grant in cycle N means: in cycle N+1, mem_web=1, mem_waddr/mem_wdata = granted addr/data, and ackX=1.
  - Latency from req to write is 1 cycle.
  - A single requester can complete at most 1 write per 2 cycles; two requesters alternating use every cycle.
- No grant in a cycle: mem_web=0 next cycle; mem_waddr/mem_wdata hold their previous values.
- clr_start in IDLE:
  - Latch clr_color and clear the counter to 0.
  - Next state is CLEAR; clr_busy=1 from the next cycle.
  - The arbiter still grants normally in the clr_start cycle.
- CLEAR:
  - Every cycle issues a write: address = counter, data = latched colour; the counter then increments.
  - No acks are given; requests stall with req held.
  - After the edge that issues address 2**ADDR_W-1, the state returns to IDLE.
  - clr_busy goes low in the cycle after the last clear write is on the port.
  - A clear is exactly 2**ADDR_W write cycles.
- clr_start during CLEAR is ignored: no restart, and the colour is not re-latched.
- Requests pending at clear end: arbitration resumes on the first IDLE cycle. The first grant appears on the port one cycle after the final clear write.
- rst_n low mid-clear or mid-request: the sequence is abandoned and the next cycle has mem_web=0. With RESET_CLEAR=1, the clear restarts from address 0 after release.
- Counter width is ADDR_W+1 or uses a terminal-count compare; it never wraps to re-issue address 0.

Decomposition:
- Package vmem_pkg:
  - ADDR_W, DATA_W, ROW_W=6, COL_W=7.
  - Enum state_t {IDLE, CLEAR}.
  - Colour constant BLACK = 15'h0.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: two eligible bits and last_gnt.
  - Outputs: one-hot grant and next last_gnt.
  - Purely combinational; the last_gnt register stays in vmem_wr_ctrl.

Test Plan:
- Reset clear (RESET_CLEAR=1): release rst_n → mem_web=1 for exactly 8192 consecutive cycles, addr 0..8191, data 15'h0; clr_busy falls one cycle after addr 8191.
- Single request: in IDLE, req0=1, addr0=13'h0A5, data0=15'h7C00 held → next cycle mem_web=1, mem_waddr=13'h0A5, mem_wdata=15'h7C00, ack0=1; req0 still high in the ack cycle → no second write in that cycle.
- Round-robin: req0 and req1 both held high → port order 0,1,0,1 on consecutive cycles with ack alternating; first grant goes to req0.
- Commanded clear: clr_start with clr_color=15'h001F while req1 is held → req1 granted in the start cycle only, then 8192 writes of 15'h001F with ack1 low throughout; ack1 appears one cycle after the last clear write.
- Ignored restart: clr_start with 15'h03E0 at clear address 100 → colour remains 15'h001F and the clear still ends at 8191 without restarting.
- Reset mid-clear: assert rst_n low at address 4000 → next cycle mem_web=0; after release the clear restarts at address 0 with colour 0.
